// File: rtl/round_timer_ctrl_pkg.sv
// Shared state encoding and timing defaults for the round countdown bar.
// Decoded by the game FSM and debug overlay as well as the controller.
package round_timer_ctrl_pkg;

    localparam int unsigned CLK_HZ           = 40_000_000;
    localparam int unsigned TICK_DIV_DEFAULT = CLK_HZ / 1000;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_ARM     = 3'd1,
        S_RUN     = 3'd2,
        S_PAUSE   = 3'd3,
        S_TIMEOUT = 3'd4,
        S_GAP     = 3'd5
    } state_e;

endpackage

// File: rtl/round_timer_ctrl_ms_tick.sv
// Gated prescaler emitting a registered 1-cycle tick every TICK_DIV running cycles.
// Holds its count while run is low; clear wins over run and swallows any tick.
module ms_tick_gen
    import round_timer_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == CW'(TICK_DIV - 1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/round_timer_ctrl.sv
// Round countdown-bar sequencer between the game FSM and the bar renderer.
// Drives bar enable/start, gated 1 ms tick, time-out/clear pulses and round count.
module round_timer_ctrl
    import round_timer_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned MAX_ROUND  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_active,
    input  logic       first_move,
    input  logic       pause_toggle,
    input  logic       level_done,
    input  logic       bar_elapsed,
    output logic       one_ms_tick,
    output logic       bar_en,
    output logic       bar_start,
    output logic       time_up,
    output logic       round_cleared,
    output logic       paused,
    output logic [3:0] round_no
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    round_q, round_d;
    logic          bar_en_q, bar_en_d;
    logic          bar_start_q, bar_start_d;
    logic          time_up_q, time_up_d;
    logic          cleared_q, cleared_d;
    logic          paused_q, paused_d;
    logic          presc_run, presc_clear;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        round_d     = round_q;
        bar_start_d = 1'b0;
        time_up_d   = 1'b0;
        cleared_d   = 1'b0;
        if (!game_active) begin
            state_d = S_OFF;
            round_d = '0;
        end else begin
            unique case (state_q)
                S_OFF:   state_d = S_ARM;
                S_ARM: begin
                    if (first_move) begin
                        state_d     = S_RUN;
                        bar_start_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (level_done) begin
                        state_d   = S_GAP;
                        gap_d     = GW'(GAP_CYCLES - 1);
                        cleared_d = 1'b1;
                        if (round_q != 4'(MAX_ROUND)) round_d = round_q + 4'd1;
                    end else if (bar_elapsed) begin
                        state_d   = S_TIMEOUT;
                        time_up_d = 1'b1;
                    end else if (pause_toggle) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: if (pause_toggle) state_d = S_RUN;
                S_TIMEOUT: state_d = S_TIMEOUT;
                S_GAP: begin
                    // Loaded with GAP_CYCLES-1 so bar_en stays low exactly GAP_CYCLES cycles.
                    if (gap_q == '0) state_d = S_ARM;
                    else             gap_d   = gap_q - 1'b1;
                end
                default: state_d = S_OFF;
            endcase
        end
        bar_en_d = state_d inside {S_ARM, S_RUN, S_PAUSE, S_TIMEOUT};
        paused_d = (state_d == S_PAUSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_OFF;
            gap_q       <= '0;
            round_q     <= '0;
            bar_en_q    <= 1'b0;
            bar_start_q <= 1'b0;
            time_up_q   <= 1'b0;
            cleared_q   <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            round_q     <= round_d;
            bar_en_q    <= bar_en_d;
            bar_start_q <= bar_start_d;
            time_up_q   <= time_up_d;
            cleared_q   <= cleared_d;
            paused_q    <= paused_d;
        end
    end

    // Clearing on the start strobe makes the first tick land a full period after bar_start.
    assign presc_run   = state_q inside {S_ARM, S_RUN};
    assign presc_clear = !game_active || (state_q inside {S_OFF, S_GAP}) || bar_start_d;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .run   (presc_run),
        .clear (presc_clear),
        .tick  (one_ms_tick)
    );

    assign bar_en        = bar_en_q;
    assign bar_start     = bar_start_q;
    assign time_up       = time_up_q;
    assign round_cleared = cleared_q;
    assign paused        = paused_q;
    assign round_no      = round_q;

endmodule
